inst_mem: RTL

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/inst_mem.sv
// Instruction memory with a combinational fetch port and a byte-stream image loader.
// A load is a 16-bit big-endian word count followed by count big-endian 32-bit words.
module inst_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst_o,
    input  logic                  load_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    output logic                  ld_ready,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [DEPTH_LOG2:0]   words_loaded
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [15:0]            count_reg, count_next;
    logic [1:0]             byte_idx_reg, byte_idx_next;
    logic [23:0]            word_buf_reg, word_buf_next;
    logic [DEPTH_LOG2:0]    words_loaded_reg, words_loaded_next;
    logic                   load_err_reg, load_err_next;

    logic                   mem_we;
    logic [DEPTH_LOG2-1:0]  mem_waddr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem [0:DEPTH-1];

    logic [15:0]            hdr_count;
    logic                   hdr_bad;
    logic [DEPTH_LOG2:0]    words_inc;
    logic                   unused_addr_bits;

    assign hdr_count = {count_reg[15:8], ld_data};
    assign hdr_bad   = (hdr_count == 16'd0) || (32'(hdr_count) > 32'(DEPTH));
    assign words_inc = words_loaded_reg + (DEPTH_LOG2+1)'(1);

    // Byte offset and upper address bits are deliberately dropped so fetches wrap.
    assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        byte_idx_next     = byte_idx_reg;
        word_buf_next     = word_buf_reg;
        words_loaded_next = words_loaded_reg;
        load_err_next     = load_err_reg;
        mem_we            = 1'b0;
        mem_waddr         = words_loaded_reg[DEPTH_LOG2-1:0];
        mem_wdata         = {word_buf_reg, ld_data};
        ld_ready          = 1'b0;
        cpu_hold          = 1'b1;
        load_done         = 1'b0;

        case (state_reg)
            IDLE: begin
                cpu_hold = 1'b0;
                if (load_start) begin
                    state_next        = HDR0;
                    words_loaded_next = '0;
                    load_err_next     = 1'b0;
                end
            end
            HDR0: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    count_next = {ld_data, 8'h00};
                    state_next = HDR1;
                end
            end
            HDR1: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    count_next = hdr_count;
                    if (hdr_bad) begin
                        load_err_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        byte_idx_next = 2'd0;
                        state_next    = DATA;
                    end
                end
            end
            DATA: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (byte_idx_reg == 2'd3) begin
                        mem_we            = 1'b1;
                        words_loaded_next = words_inc;
                        byte_idx_next     = 2'd0;
                        if (32'(words_inc) == 32'(count_reg))
                            state_next = DONE;
                    end else begin
                        word_buf_next = {word_buf_reg[15:0], ld_data};
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            byte_idx_reg     <= '0;
            word_buf_reg     <= '0;
            words_loaded_reg <= '0;
            load_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            byte_idx_reg     <= byte_idx_next;
            word_buf_reg     <= word_buf_next;
            words_loaded_reg <= words_loaded_next;
            load_err_reg     <= load_err_next;
        end
    end

    // Memory is never cleared; reset only suppresses a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        inst_o = 32'h0;
        if (ce && !cpu_hold)
            inst_o = mem[addr[DEPTH_LOG2+1:2]];
    end

    assign load_err     = load_err_reg;
    assign words_loaded = words_loaded_reg;

endmodule
